// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sweep sequencer.
package led_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_ACK,
        RD,
        RD_ACK,
        GAP,
        DONE
    } state_t;

    localparam logic [15:0] LED_ADDR       = 16'h0000;
    localparam logic [15:0] LED_START_DATA = 16'h0001;
    localparam int          LED_IDX_MSB    = 3;

    // Sweep counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wb_xact.sv
// Single Wishbone transaction engine: one request in flight, stall-aware
// strobe, cyc held until ack, and a strobe-to-ack timeout.
module wb_xact #(
    parameter int TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] wdata,
    input  logic        abort,
    input  logic        wb_stall,
    input  logic        wb_ack,
    input  logic [15:0] wb_rdata,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [15:0] wb_wdata,
    output logic [15:0] rdata,
    output logic        done,
    output logic        timeout
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt;

    // An ack only means something while our cycle is open.
    assign done    = wb_cyc && wb_ack;
    assign timeout = wb_cyc && !wb_ack && (tcnt == TW'(TIMEOUT - 1));
    assign rdata   = wb_rdata;

    // Bus handshake; the async reset drops cyc/stb without waiting for a clock.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_wdata <= '0;
            tcnt     <= '0;
        end else if (abort || done || timeout) begin
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_wdata <= '0;
            tcnt     <= '0;
        end else if (req && !wb_cyc) begin
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            wb_we    <= we;
            wb_wdata <= we ? wdata : 16'h0000;
            tcnt     <= '0;
        end else if (wb_cyc) begin
            if (wb_stb && !wb_stall)
                wb_stb <= 1'b0;
            tcnt <= tcnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_sweep_seq.sv
// Wishbone master that runs N LED sweeps: start write, poll the index until
// it returns to 0, wait a programmable gap, repeat.
module led_sweep_seq #(
    parameter int GAP_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [7:0]       i_count,
    input  logic [GAP_W-1:0] i_gap,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [7:0]       o_sweeps,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    output logic             o_wb_we,
    output logic [15:0]      o_wb_addr,
    output logic [15:0]      o_wb_data,
    input  logic             i_wb_stall,
    input  logic             i_wb_ack,
    input  logic [15:0]      i_wb_data
);
    import led_seq_pkg::*;

    state_t                 state;
    logic [7:0]             cnt_q;
    logic [GAP_W-1:0]       gap_q;
    logic [GAP_W-1:0]       gcnt;
    logic                   launch;
    logic                   launch_we;
    logic                   x_done;
    logic                   x_timeout;
    logic [15:0]            x_rdata;
    logic [LED_IDX_MSB:0]   rd_idx;
    logic [7:0]             sweeps_inc;
    logic                   unused_rdata;

    assign o_wb_addr    = LED_ADDR;
    assign rd_idx       = x_rdata[LED_IDX_MSB:0];
    assign unused_rdata = ^x_rdata[15:LED_IDX_MSB+1];
    assign sweeps_inc   = sat_inc8(o_sweeps);

    // Requests are issued in the cycle before the strobe must appear: on the
    // accepted start, on the last gap cycle, or once the previous cyc has dropped.
    assign launch = !i_abort && (
                      (state == IDLE && i_start && i_count != 8'd0) ||
                      (state == GAP  && gcnt == GAP_W'(1)) ||
                      ((state == WR || state == RD) && !o_wb_cyc));
    assign launch_we = (state != RD);

    wb_xact #(.TIMEOUT(TIMEOUT)) u_xact (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .req       (launch),
        .we        (launch_we),
        .wdata     (LED_START_DATA),
        .abort     (i_abort),
        .wb_stall  (i_wb_stall),
        .wb_ack    (i_wb_ack),
        .wb_rdata  (i_wb_data),
        .wb_cyc    (o_wb_cyc),
        .wb_stb    (o_wb_stb),
        .wb_we     (o_wb_we),
        .wb_wdata  (o_wb_data),
        .rdata     (x_rdata),
        .done      (x_done),
        .timeout   (x_timeout)
    );

    // Sequencer FSM with sweep and gap counters; abort beats ack and timeout.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            o_sweeps <= 8'd0;
            cnt_q    <= 8'd0;
            gap_q    <= '0;
            gcnt     <= '0;
        end else begin
            o_done <= 1'b0;
            if (state != IDLE && i_abort) begin
                state  <= IDLE;
                o_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (i_start && !i_abort) begin
                        o_err    <= 1'b0;
                        o_sweeps <= 8'd0;
                        cnt_q    <= i_count;
                        gap_q    <= i_gap;
                        o_busy   <= 1'b1;
                        if (i_count == 8'd0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= WR;
                        end
                    end
                    WR, WR_ACK: begin
                        if (x_timeout) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            o_err  <= 1'b1;
                        end else if (x_done) begin
                            state <= RD;
                        end else if (state == WR && o_wb_stb && !i_wb_stall) begin
                            state <= WR_ACK;
                        end
                    end
                    RD, RD_ACK: begin
                        if (x_timeout) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            o_err  <= 1'b1;
                        end else if (x_done) begin
                            if (rd_idx != '0) begin
                                state <= RD;
                            end else begin
                                o_sweeps <= sweeps_inc;
                                if (sweeps_inc == cnt_q) begin
                                    state  <= DONE;
                                    o_done <= 1'b1;
                                end else if (gap_q != '0) begin
                                    state <= GAP;
                                    gcnt  <= gap_q;
                                end else begin
                                    state <= WR;
                                end
                            end
                        end else if (state == RD && o_wb_stb && !i_wb_stall) begin
                            state <= RD_ACK;
                        end
                    end
                    GAP: begin
                        if (gcnt == GAP_W'(1))
                            state <= WR;
                        else
                            gcnt <= gcnt - 1'b1;
                    end
                    DONE: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_sweep_seq.sv
// Directed bench for led_sweep_seq with a small Wishbone slave model.
module tb_led_sweep_seq;
    localparam int GAP_W   = 16;
    localparam int TIMEOUT = 64;

    logic             i_clk = 1'b0;
    logic             i_reset_n = 1'b0;
    logic             i_start = 1'b0;
    logic [7:0]       i_count = 8'd0;
    logic [GAP_W-1:0] i_gap = '0;
    logic             i_abort = 1'b0;
    logic             o_busy, o_done, o_err;
    logic [7:0]       o_sweeps;
    logic             o_wb_cyc, o_wb_stb, o_wb_we;
    logic [15:0]      o_wb_addr, o_wb_data;
    logic             i_wb_stall, i_wb_ack;
    logic [15:0]      i_wb_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    led_sweep_seq #(.GAP_W(GAP_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_count(i_count),
        .i_gap(i_gap), .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err), .o_sweeps(o_sweeps), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
    );

    // Slave: optional write stall, ack one cycle after acceptance,
    // index reads 1..15 then 0 after each write.
    int         stall_cfg = 0;
    int         stall_used;
    bit         no_ack = 1'b0;
    logic [3:0] seq;

    assign i_wb_stall = o_wb_stb && o_wb_we && (stall_used < stall_cfg);

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            i_wb_ack   <= 1'b0;
            i_wb_data  <= 16'h0000;
            seq        <= 4'd0;
            stall_used <= 0;
        end else begin
            i_wb_ack  <= 1'b0;
            i_wb_data <= 16'h0000;
            if (o_wb_cyc && o_wb_stb && i_wb_stall)
                stall_used <= stall_used + 1;
            if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
                stall_used <= 0;
                i_wb_ack   <= !no_ack;
                if (o_wb_we) begin
                    seq <= 4'd1;
                end else begin
                    i_wb_data <= {12'h000, seq};
                    seq       <= (seq == 4'd15 || seq == 4'd0) ? 4'd0 : seq + 4'd1;
                end
            end
        end
    end

    // Bus/event monitors: acceptances, write strobe cycles, done pulses,
    // and the cyc-low run preceding each write.
    int n_wr = 0, n_rd = 0, n_done = 0, n_stbwr = 0, low_run = 0;
    int wr_gaps[$];

    always @(posedge i_clk) begin
        if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
            if (o_wb_we) n_wr++;
            else         n_rd++;
        end
        if (o_wb_stb && o_wb_we) n_stbwr++;
        if (o_done) n_done++;
        if (o_wb_cyc) begin
            if (low_run != 0 && o_wb_we) wr_gaps.push_back(low_run);
            low_run = 0;
        end else begin
            low_run++;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [7:0] c, input logic [GAP_W-1:0] g);
        i_count = c;
        i_gap   = g;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && o_busy; i++) tick();
        chk(tag, 32'(o_busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  b_wr, b_rd, b_done, b_stb, b_gap;
        bit  found;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_busy",   32'(o_busy),    32'd0);
        chk("rst_done",   32'(o_done),    32'd0);
        chk("rst_err",    32'(o_err),     32'd0);
        chk("rst_sweeps", 32'(o_sweeps),  32'd0);
        chk("rst_cyc",    32'(o_wb_cyc),  32'd0);
        chk("rst_stb",    32'(o_wb_stb),  32'd0);
        chk("rst_data",   32'(o_wb_data), 32'd0);
        i_reset_n = 1'b1;
        tick();

        // 1) one sweep, no gap
        b_wr = n_wr; b_rd = n_rd; b_done = n_done;
        go(8'd1, 16'd0);
        chk("t1_busy",  32'(o_busy),    32'd1);
        chk("t1_cyc",   32'(o_wb_cyc),  32'd1);
        chk("t1_stb",   32'(o_wb_stb),  32'd1);
        chk("t1_we",    32'(o_wb_we),   32'd1);
        chk("t1_wdata", 32'(o_wb_data), 32'd1);
        chk("t1_addr",  32'(o_wb_addr), 32'd0);
        wait_idle("t1_idle");
        chk("t1_writes", 32'(n_wr - b_wr),     32'd1);
        chk("t1_reads",  32'(n_rd - b_rd),     32'd16);
        chk("t1_dones",  32'(n_done - b_done), 32'd1);
        chk("t1_sweeps", 32'(o_sweeps),        32'd1);
        chk("t1_cyc_lo", 32'(o_wb_cyc),        32'd0);
        chk("t1_err",    32'(o_err),           32'd0);

        // 2) three sweeps, gap of 10
        b_wr = n_wr; b_rd = n_rd; b_done = n_done; b_gap = wr_gaps.size();
        go(8'd3, 16'd10);
        wait_idle("t2_idle");
        chk("t2_writes", 32'(n_wr - b_wr),           32'd3);
        chk("t2_reads",  32'(n_rd - b_rd),           32'd48);
        chk("t2_dones",  32'(n_done - b_done),       32'd1);
        chk("t2_sweeps", 32'(o_sweeps),              32'd3);
        chk("t2_ngaps",  32'(wr_gaps.size() - b_gap), 32'd3);
        chk("t2_gap1", (wr_gaps.size() > b_gap + 1) ? 32'(wr_gaps[b_gap + 1]) : 32'hFFFF_FFFF, 32'd10);
        chk("t2_gap2", (wr_gaps.size() > b_gap + 2) ? 32'(wr_gaps[b_gap + 2]) : 32'hFFFF_FFFF, 32'd10);

        // 3) write stalled 5 cycles
        b_stb = n_stbwr; b_done = n_done;
        stall_cfg = 5;
        go(8'd1, 16'd0);
        wait_idle("t3_idle");
        stall_cfg = 0;
        chk("t3_stb_cycles", 32'(n_stbwr - b_stb),  32'd6);
        chk("t3_err",        32'(o_err),            32'd0);
        chk("t3_sweeps",     32'(o_sweeps),         32'd1);
        chk("t3_dones",      32'(n_done - b_done),  32'd1);

        // 4) no ack -> timeout 64 cycles after strobe
        no_ack = 1'b1;
        b_done = n_done;
        go(8'd1, 16'd0);
        chk("t4_stb_at_t", 32'(o_wb_stb), 32'd1);
        repeat (63) tick();
        chk("t4_cyc_t63", 32'(o_wb_cyc), 32'd1);
        chk("t4_err_t63", 32'(o_err),    32'd0);
        tick();
        chk("t4_cyc_t64",  32'(o_wb_cyc),        32'd0);
        chk("t4_err_t64",  32'(o_err),           32'd1);
        chk("t4_busy_t64", 32'(o_busy),          32'd0);
        chk("t4_no_done",  32'(n_done - b_done), 32'd0);
        no_ack = 1'b0;
        go(8'd1, 16'd0);
        chk("t4_err_clr", 32'(o_err), 32'd0);
        wait_idle("t4_idle");
        chk("t4_sweeps", 32'(o_sweeps), 32'd1);

        // 5) abort in the first read-ack of sweep 2 of 4
        b_wr = n_wr; b_done = n_done;
        go(8'd4, 16'd0);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (o_wb_cyc && !o_wb_stb && !o_wb_we && (n_wr - b_wr) == 2) found = 1'b1;
            else tick();
        end
        chk("t5_found", 32'(found), 32'd1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("t5_cyc",    32'(o_wb_cyc), 32'd0);
        chk("t5_stb",    32'(o_wb_stb), 32'd0);
        chk("t5_busy",   32'(o_busy),   32'd0);
        chk("t5_sweeps", 32'(o_sweeps), 32'd1);
        repeat (5) tick();
        chk("t5_no_done", 32'(n_done - b_done), 32'd0);
        chk("t5_err",     32'(o_err),           32'd0);
        chk("t5_sweeps2", 32'(o_sweeps),        32'd1);

        // 6) count 0, ignored starts
        b_wr = n_wr; b_done = n_done;
        go(8'd0, 16'd0);
        chk("t6_done",  32'(o_done),   32'd1);
        chk("t6_busy",  32'(o_busy),   32'd1);
        chk("t6_stb",   32'(o_wb_stb), 32'd0);
        chk("t6_cyc",   32'(o_wb_cyc), 32'd0);
        tick();
        chk("t6_done2", 32'(o_done),          32'd0);
        chk("t6_idle",  32'(o_busy),          32'd0);
        chk("t6_dones", 32'(n_done - b_done), 32'd1);
        chk("t6_nowr",  32'(n_wr - b_wr),     32'd0);

        b_wr = n_wr;
        go(8'd1, 16'd0);
        repeat (3) tick();
        i_count = 8'd2; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_idle("t6_busy_idle");
        chk("t6_busy_sweeps", 32'(o_sweeps),    32'd1);
        chk("t6_busy_writes", 32'(n_wr - b_wr), 32'd1);

        i_count = 8'd1; i_start = 1'b1; i_abort = 1'b1;
        tick();
        i_start = 1'b0; i_abort = 1'b0;
        chk("t6_stab_busy", 32'(o_busy),   32'd0);
        chk("t6_stab_cyc",  32'(o_wb_cyc), 32'd0);

        i_reset_n = 1'b0; i_start = 1'b1;
        tick();
        i_start = 1'b0; i_reset_n = 1'b1;
        tick();
        chk("t6_rst_busy", 32'(o_busy),   32'd0);
        chk("t6_rst_cyc",  32'(o_wb_cyc), 32'd0);

        // Async reset mid-transaction drops the bus without a clock edge
        go(8'd1, 16'd0);
        chk("ar_cyc_before", 32'(o_wb_cyc), 32'd1);
        #2 i_reset_n = 1'b0;
        #1;
        chk("ar_cyc",  32'(o_wb_cyc), 32'd0);
        chk("ar_stb",  32'(o_wb_stb), 32'd0);
        chk("ar_busy", 32'(o_busy),   32'd0);
        i_reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
